// File: rtl/mmu_array.sv
// Purpose : output-stationary ROWS x COLS signed systolic matrix multiply with input skew, drain and row read-out.
// Latency : out_valid rises ROWS+COLS-2 cycles after the beat carrying in_last; then one row per cycle.
// Backpr. : in_ready low in DRAIN/OUT; out_data/out_row hold while out_valid & !out_ready.
//           Optional MMU_SAT_EN: accumulators saturate instead of wrapping.
module mmu_array #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_last,
    input  logic [ROWS*DATA_WIDTH-1:0]    data_in,
    input  logic [COLS*DATA_WIDTH-1:0]    weight_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [COLS*ACC_WIDTH-1:0]     out_data,
    output logic [$clog2(ROWS)-1:0]       out_row,
    output logic                          busy
);

    localparam int RW        = $clog2(ROWS);
    localparam int DRAIN_CYC = ROWS + COLS - 2;
    localparam int CW        = $clog2(DRAIN_CYC);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, OUT} state_t;

    state_t           state;
    logic [CW-1:0]    drain_cnt;

    logic             accept;
    logic             shift_en;
    logic             clear;

    // Edge sources (zeroed while draining)
    logic signed [DATA_WIDTH-1:0] a_src [ROWS];
    logic signed [DATA_WIDTH-1:0] b_src [COLS];

    // Skew chains: row r uses the first r taps, column c the first c taps
    logic signed [DATA_WIDTH-1:0] a_skew [ROWS][ROWS-1];
    logic signed [DATA_WIDTH-1:0] b_skew [COLS][COLS-1];

    // Cell-to-cell pipes: data moves right, weights move down
    logic signed [DATA_WIDTH-1:0] a_pipe [ROWS][COLS-1];
    logic signed [DATA_WIDTH-1:0] b_pipe [ROWS-1][COLS];

    logic signed [DATA_WIDTH-1:0]   a_in    [ROWS][COLS];
    logic signed [DATA_WIDTH-1:0]   b_in    [ROWS][COLS];
    logic signed [2*DATA_WIDTH-1:0] prod    [ROWS][COLS];
    logic signed [ACC_WIDTH-1:0]    acc     [ROWS][COLS];
    logic signed [ACC_WIDTH-1:0]    acc_nxt [ROWS][COLS];

`ifdef MMU_SAT_EN
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    logic signed [ACC_WIDTH:0] sum_w [ROWS][COLS];
`endif

    assign in_ready  = (state == IDLE) || (state == FEED);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);
    assign accept    = in_valid & in_ready;
    assign shift_en  = accept | (state == DRAIN);
    assign clear     = out_valid & out_ready & (out_row == RW'(ROWS - 1));

    // Select beat data at the array edges, injecting zeros during drain
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            a_src[r] = (state == DRAIN) ? '0 : $signed(data_in[r*DATA_WIDTH +: DATA_WIDTH]);
        end
        for (int c = 0; c < COLS; c++) begin
            b_src[c] = (state == DRAIN) ? '0 : $signed(weight_in[c*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Route each cell's operands from the skew taps or its neighbours
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (c == 0) begin
                    a_in[r][c] = (r == 0) ? a_src[r] : a_skew[r][(r > 0) ? r - 1 : 0];
                end else begin
                    a_in[r][c] = a_pipe[r][(c > 0) ? c - 1 : 0];
                end
                if (r == 0) begin
                    b_in[r][c] = (c == 0) ? b_src[c] : b_skew[c][(c > 0) ? c - 1 : 0];
                end else begin
                    b_in[r][c] = b_pipe[(r > 0) ? r - 1 : 0][c];
                end
            end
        end
    end

    // MAC arithmetic: full-width product, sign-extended, wrapped or clamped
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                prod[r][c] = a_in[r][c] * b_in[r][c];
`ifdef MMU_SAT_EN
                sum_w[r][c] = $signed({acc[r][c][ACC_WIDTH-1], acc[r][c]})
                            + $signed((ACC_WIDTH+1)'(prod[r][c]));
                if (sum_w[r][c][ACC_WIDTH] != sum_w[r][c][ACC_WIDTH-1]) begin
                    acc_nxt[r][c] = sum_w[r][c][ACC_WIDTH] ? $signed(ACC_MIN) : $signed(ACC_MAX);
                end else begin
                    acc_nxt[r][c] = sum_w[r][c][ACC_WIDTH-1:0];
                end
`else
                acc_nxt[r][c] = acc[r][c] + ACC_WIDTH'(prod[r][c]);
`endif
            end
        end
    end

    // Datapath registers: shift and accumulate on enable, wipe after final row
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int r = 0; r < ROWS; r++)
                for (int j = 0; j < ROWS - 1; j++) a_skew[r][j] <= '0;
            for (int c = 0; c < COLS; c++)
                for (int j = 0; j < COLS - 1; j++) b_skew[c][j] <= '0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS - 1; c++) a_pipe[r][c] <= '0;
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++) b_pipe[r][c] <= '0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) acc[r][c] <= '0;
        end else if (clear || shift_en) begin
            for (int r = 0; r < ROWS; r++) begin
                a_skew[r][0] <= clear ? '0 : a_src[r];
                for (int j = 1; j < ROWS - 1; j++) a_skew[r][j] <= clear ? '0 : a_skew[r][j-1];
            end
            for (int c = 0; c < COLS; c++) begin
                b_skew[c][0] <= clear ? '0 : b_src[c];
                for (int j = 1; j < COLS - 1; j++) b_skew[c][j] <= clear ? '0 : b_skew[c][j-1];
            end
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS - 1; c++) a_pipe[r][c] <= clear ? '0 : a_in[r][c];
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++) b_pipe[r][c] <= clear ? '0 : b_in[r][c];
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) acc[r][c] <= clear ? '0 : acc_nxt[r][c];
        end
    end

    // Control FSM: feed beats, drain the wavefront, then present rows in order
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            drain_cnt <= '0;
            out_row   <= '0;
        end else begin
            case (state)
                IDLE, FEED: begin
                    if (accept) begin
                        if (in_last) begin
                            state     <= DRAIN;
                            drain_cnt <= CW'(DRAIN_CYC - 1);
                        end else begin
                            state <= FEED;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state   <= OUT;
                        out_row <= '0;
                    end else begin
                        drain_cnt <= drain_cnt - CW'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        if (out_row == RW'(ROWS - 1)) begin
                            state   <= IDLE;
                            out_row <= '0;
                        end else begin
                            out_row <= out_row + RW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Present the current row only while it is valid
    always_comb begin
        out_data = '0;
        if (state == OUT) begin
            for (int c = 0; c < COLS; c++) begin
                out_data[c*ACC_WIDTH +: ACC_WIDTH] = acc[out_row][c];
            end
        end
    end

endmodule

// File: tb/tb_mmu_array.sv
// Bench for mmu_array: a 4x4/16/40 instance plus a lock-stepped 4x4/8/16 instance for overflow behaviour.
// Expected matrices come from a sum-of-products reference with explicit wrap/clamp arithmetic.
// Read-out may be stalled on a chosen row; illegal input beats may be injected while in_ready is low.
module tb_mmu_array;
    localparam int R = 4, C = 4, DW = 16, AW = 40, DW8 = 8, AW8 = 16, MAXK = 8;
`ifdef MMU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, in_valid, in_last, out_ready;
    logic [R*DW-1:0]  data_in;
    logic [C*DW-1:0]  weight_in;
    logic [R*DW8-1:0] data8;
    logic [C*DW8-1:0] weight8;
    logic in_ready, out_valid, busy, in_ready8, out_valid8, busy8;
    logic [C*AW-1:0]  out_data;
    logic [C*AW8-1:0] out_data8;
    logic [1:0] out_row, out_row8;

    always #5 clk = ~clk;

    for (genvar g = 0; g < R; g++) begin : g_d8
        assign data8[g*DW8 +: DW8]   = data_in[g*DW +: DW8];
        assign weight8[g*DW8 +: DW8] = weight_in[g*DW +: DW8];
    end

    mmu_array #(.ROWS(R), .COLS(C), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
        .clk_i(clk), .rst_i(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .data_in(data_in), .weight_in(weight_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .busy(busy));

    mmu_array #(.ROWS(R), .COLS(C), .DATA_WIDTH(DW8), .ACC_WIDTH(AW8)) dut8 (
        .clk_i(clk), .rst_i(rst_n), .in_valid(in_valid), .in_ready(in_ready8), .in_last(in_last),
        .data_in(data8), .weight_in(weight8), .out_valid(out_valid8), .out_ready(out_ready),
        .out_data(out_data8), .out_row(out_row8), .busy(busy8));

    int checks = 0, errors = 0;
    int A [R][MAXK];
    int B [MAXK][C];
    int K;
    logic [AW-1:0]  got_d  [R][C];
    logic [AW8-1:0] got_d8 [R][C];
    int got_row [R];
    int lat;
    bit tmo, ready_ok, stall_ok, busy_after, ready_after;

    // Sign-extend the low w bits of v
    function automatic longint sx(input longint v, input int w);
        longint m = longint'(1) << w;
        longint t = v & (m - 1);
        if (t >= m / 2) t -= m;
        return t;
    endfunction

    // C[r][c] = sum_k A[r][k]*B[k][c] with operands of width dw, accumulator of width w
    function automatic longint ref_c(input int r, input int c, input int w, input int dw);
        longint s = 0;
        longint hi = (longint'(1) << (w - 1)) - 1;
        longint lo = -(longint'(1) << (w - 1));
        for (int k = 0; k < K; k++) begin
            s += sx(A[r][k], dw) * sx(B[k][c], dw);
            if (SAT) begin
                if (s > hi) s = hi;
                if (s < lo) s = lo;
            end else begin
                s = sx(s, w);
            end
        end
        return s;
    endfunction

    // Stream K beats; mode 0 back-to-back, 1 alternate bubbles plus 3 idle mid-stream, 2 random gaps
    task automatic feed(input int mode);
        ready_ok = 1'b1;
        for (int k = 0; k < K; k++) begin
            @(negedge clk);
            if (mode == 1 && k > 0) begin
                @(negedge clk);
                if (k == 2) repeat (3) @(negedge clk);
            end
            if (mode == 2) repeat ($urandom_range(0, 2)) @(negedge clk);
            if (!in_ready) ready_ok = 1'b0;
            in_valid = 1'b1;
            in_last  = (k == K - 1);
            for (int r = 0; r < R; r++) data_in[r*DW +: DW] = A[r][k][DW-1:0];
            for (int c = 0; c < C; c++) weight_in[c*DW +: DW] = B[k][c][DW-1:0];
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    // Wait for results and read all rows; stall_row holds out_ready low 5 cycles on that row
    task automatic collect(input int stall_row, input bit noise);
        logic [C*AW-1:0] snap;
        tmo = 1'b0; lat = 0; stall_ok = 1'b1; out_ready = 1'b1;
        while (!out_valid) begin
            if (lat >= 40) begin
                tmo = 1'b1; in_valid = 1'b0; return;
            end
            if (noise) begin
                in_valid  = 1'b1;
                in_last   = 1'($urandom);
                data_in   = {$urandom, $urandom};
                weight_in = {$urandom, $urandom};
            end
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        for (int i = 0; i < R; i++) begin
            if (!out_valid) begin
                tmo = 1'b1; return;
            end
            got_row[i] = int'(out_row);
            snap = out_data;
            for (int c = 0; c < C; c++) begin
                got_d[i][c]  = out_data[c*AW +: AW];
                got_d8[i][c] = out_data8[c*AW8 +: AW8];
            end
            if (i == stall_row) begin
                out_ready = 1'b0;
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    if (!out_valid || out_data !== snap || int'(out_row) != i) stall_ok = 1'b0;
                end
                out_ready = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        busy_after  = busy;
        ready_after = in_ready;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        data_in = '0; weight_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0 || out_row !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b busy=%b row=%0d data=%h required 1 0 0 0 0",
                     in_ready, out_valid, busy, out_row, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_identity();
        K = 4;
        for (int r = 0; r < R; r++) for (int k = 0; k < K; k++) A[r][k] = (r == k) ? 1 : 0;
        for (int k = 0; k < K; k++) for (int c = 0; c < C; c++) B[k][c] = 10 * k + c;
    endtask

    task automatic test_identity();
        load_identity();
        feed(0);
        collect(R, 1'b0);
        checks++;
        if (tmo || lat != 6) begin
            errors++; $display("FAIL ident_latency got %0d (timeout %0d) required 6", lat, tmo);
        end
        for (int i = 0; i < R; i++) begin
            checks++;
            if (got_row[i] != i) begin errors++; $display("FAIL ident_row got %0d required %0d", got_row[i], i); end
            for (int c = 0; c < C; c++) begin
                checks++;
                if (got_d[i][c] !== AW'(10 * i + c)) begin
                    errors++; $display("FAIL ident_data r%0d c%0d got %0d required %0d", i, c, $signed(got_d[i][c]), 10 * i + c);
                end
            end
        end
        checks++;
        if (busy_after !== 1'b0 || ready_after !== 1'b1) begin
            errors++; $display("FAIL ident_end got busy=%b rdy=%b required 0 1", busy_after, ready_after);
        end
    endtask

    task automatic test_bubbles();
        load_identity();
        feed(1);
        collect(R, 1'b0);
        checks++;
        if (!ready_ok) begin errors++; $display("FAIL bubble_ready got in_ready low during feed required high"); end
        checks++;
        if (tmo || lat != 6) begin errors++; $display("FAIL bubble_latency got %0d required 6", lat); end
        for (int i = 0; i < R; i++) for (int c = 0; c < C; c++) begin
            logic [AW-1:0] e;
            e = AW'(ref_c(i, c, AW, DW));
            checks++;
            if (got_d[i][c] !== e) begin
                errors++; $display("FAIL bubble_data r%0d c%0d got %0d required %0d", i, c, $signed(got_d[i][c]), $signed(e));
            end
        end
    endtask

    task automatic test_backpressure();
        load_identity();
        feed(0);
        collect(1, 1'b0);
        checks++;
        if (tmo || !stall_ok) begin errors++; $display("FAIL bp_stable got stable=%0d timeout=%0d required 1 0", stall_ok, tmo); end
        for (int i = 0; i < R; i++) begin
            checks++;
            if (got_row[i] != i || got_d[i][C-1] !== AW'(10 * i + C - 1)) begin
                errors++; $display("FAIL bp_row slot %0d got row %0d data %0d required row %0d data %0d",
                                   i, got_row[i], $signed(got_d[i][C-1]), i, 10 * i + C - 1);
            end
        end
        checks++;
        if (busy_after !== 1'b0) begin errors++; $display("FAIL bp_busy got %b required 0", busy_after); end
    endtask

    task automatic test_overflow();
        logic [AW8-1:0] e8;
        K = 4;
        for (int r = 0; r < R; r++) for (int k = 0; k < K; k++) A[r][k] = 127;
        for (int k = 0; k < K; k++) for (int c = 0; c < C; c++) B[k][c] = 127;
        e8 = SAT ? AW8'(32767) : AW8'(-1020);
        feed(0);
        collect(R, 1'b0);
        for (int i = 0; i < R; i++) for (int c = 0; c < C; c++) begin
            checks++;
            if (got_d8[i][c] !== e8) begin
                errors++; $display("FAIL ovf_narrow r%0d c%0d got %0d required %0d", i, c, $signed(got_d8[i][c]), $signed(e8));
            end
            checks++;
            if (got_d[i][c] !== AW'(64516)) begin
                errors++; $display("FAIL ovf_wide r%0d c%0d got %0d required 64516", i, c, $signed(got_d[i][c]));
            end
        end
    endtask

    task automatic test_reset_drain();
        K = 3;
        for (int r = 0; r < R; r++) for (int k = 0; k < K; k++) A[r][k] = 1000 + r + k;
        for (int k = 0; k < K; k++) for (int c = 0; c < C; c++) B[k][c] = 2000 - c;
        feed(0);
        @(posedge clk); @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_drain got vld=%b busy=%b rdy=%b required 0 0 1", out_valid, busy, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        K = 1;
        for (int r = 0; r < R; r++) A[r][0] = 3;
        for (int c = 0; c < C; c++) B[0][c] = 5;
        feed(0);
        collect(R, 1'b0);
        checks++;
        if (tmo) begin errors++; $display("FAIL rst_rerun_timeout got timeout required results"); end
        for (int i = 0; i < R; i++) for (int c = 0; c < C; c++) begin
            checks++;
            if (got_d[i][c] !== AW'(15)) begin
                errors++; $display("FAIL rst_rerun r%0d c%0d got %0d required 15", i, c, $signed(got_d[i][c]));
            end
        end
    endtask

    task automatic test_single_signed();
        K = 1;
        for (int r = 0; r < R; r++) A[r][0] = -2;
        for (int c = 0; c < C; c++) B[0][c] = 3;
        feed(0);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL single_drain got rdy=%b busy=%b required 0 1", in_ready, busy);
        end
        collect(R, 1'b0);
        checks++;
        if (tmo || lat != 6) begin errors++; $display("FAIL single_latency got %0d required 6", lat); end
        for (int i = 0; i < R; i++) for (int c = 0; c < C; c++) begin
            checks++;
            if (got_d[i][c] !== AW'(-6)) begin
                errors++; $display("FAIL single_data r%0d c%0d got %0d required -6", i, c, $signed(got_d[i][c]));
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [DW-1:0] v;
            K = $urandom_range(1, MAXK);
            for (int r = 0; r < R; r++) for (int k = 0; k < K; k++) begin
                v = DW'($urandom); A[r][k] = int'($signed(v));
            end
            for (int k = 0; k < K; k++) for (int c = 0; c < C; c++) begin
                v = DW'($urandom); B[k][c] = int'($signed(v));
            end
            feed(2);
            collect($urandom_range(0, R), 1'b1);
            checks++;
            if (tmo || lat != 6) begin errors++; $display("FAIL rand_latency it%0d got %0d required 6", it, lat); end
            for (int i = 0; i < R; i++) for (int c = 0; c < C; c++) begin
                logic [AW-1:0]  e;
                logic [AW8-1:0] e8;
                e  = AW'(ref_c(i, c, AW, DW));
                e8 = AW8'(ref_c(i, c, AW8, DW8));
                checks++;
                if (got_d[i][c] !== e || got_d8[i][c] !== e8) begin
                    errors++;
                    $display("FAIL rand_data it%0d r%0d c%0d got %0d/%0d required %0d/%0d", it, i, c,
                             $signed(got_d[i][c]), $signed(got_d8[i][c]), $signed(e), $signed(e8));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_bubbles();
        test_backpressure();
        test_overflow();
        test_reset_drain();
        test_single_signed();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmu_array.md
# mmu_array

Parametrised output-stationary systolic matrix-multiply array: a ROWS×COLS grid of signed integer MAC cells with built-in input skewing, a drain sequencer and a ready/valid result read-out. It is the next-generation replacement for the fixed 4×4 command-driven MMU. Matrix data streams in one K-step per beat, and results stream out one row per beat, with no host-managed skew or trigger sequencing.

## Interface
- ROWS, 4, array rows (≥2)
- COLS, 4, array columns (≥2)
- DATA_WIDTH, 16, signed operand width
- ACC_WIDTH, 40, signed accumulator width (≥2·DATA_WIDTH)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_last  in  1  marks final K-step of current product
- data_in  in  ROWS·DATA_WIDTH  A[r][k] in slice r (row 0 in LSBs)
- weight_in  in  COLS·DATA_WIDTH  B[k][c] in slice c (col 0 in LSBs)
- out_valid  out  1  result row valid
- out_ready  in  1  result row consumed when out_valid & out_ready
- out_data  out  COLS·ACC_WIDTH  C[r][c] in slice c (col 0 in LSBs)
- out_row  out  $clog2(ROWS)  row index of out_data
- busy  out  1  high in FEED, DRAIN, OUT

## Operation
- Each accepted beat is one K-step. The product is C[r][c] = Σk A[r][k]·B[k][c].
- Skew: row r of data_in is delayed r enabled shifts. Column c of weight_in is delayed c enabled shifts. Data moves right and weights move down one cell per enabled shift.
- Shift enable = accepted beat, or any DRAIN cycle. With no enable, every skew register, cell pipeline register and accumulator holds, so input bubbles do not change results.
- In DRAIN, zeros are injected at all row and column inputs.
- Cell: acc ← acc + sext(a·b) on an enabled shift. The product is full 2·DATA_WIDTH signed, sign-extended to ACC_WIDTH. The accumulator wraps modulo 2^ACC_WIDTH (see Configuration).
- FSM:
  - IDLE → FEED on the first accepted beat. A beat with in_last in IDLE goes directly to DRAIN.
  - FEED → DRAIN on an accepted beat with in_last.
  - DRAIN lasts exactly ROWS+COLS-2 cycles (down-counter), then → OUT.
  - OUT: rows 0..ROWS-1 are presented in order. After the handshake on row ROWS-1, all accumulators clear to 0 and the FSM → IDLE.
- in_ready = 1 in IDLE and FEED, 0 in DRAIN and OUT.
- out_valid = 1 only in OUT. out_data and out_row are held stable while out_valid & !out_ready.

## Timing
- Reset (asynchronous assert, any state): state IDLE, all accumulators, skew and pipe registers 0; in_ready=1, out_valid=0, out_data=0, out_row=0, busy=0. Effective the same cycle, including mid-DRAIN or mid-OUT; no partial result is emitted.
- Input throughput: 1 beat/cycle.
- Latency: out_valid rises immediately after the (ROWS+COLS-2)th rising edge following the edge that accepted in_last (6 for 4×4).
- Read-out: 1 row/cycle under continuous out_ready, ROWS cycles minimum.
- in_ready rises the cycle after the final row handshake. A new product may then start with zeroed accumulators.
- in_valid while in_ready=0 is ignored; no state change.

## Configuration
- MMU_SAT_EN defined: accumulate saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. Once saturated, the value stays clamped until a further accumulate moves it back inside range.
- MMU_SAT_EN undefined: two's-complement wrap-around; no saturation logic is instantiated.

## Test plan
- 4×4 identity: A=I, B[k][c]=10k+c, K=4 continuous beats -> row r reads out B[r][*], out_row=0,1,2,3; out_valid rises exactly 6 cycles after the last-beat edge.
- Bubbles: same stimulus with in_valid low on alternate cycles plus 3 idle cycles mid-stream -> bit-identical results; in_ready=1 throughout FEED.
- Backpressure: out_ready low for 5 cycles while row 1 is presented -> out_data/out_row stable, no row skipped; busy falls after the row-3 handshake.
- Overflow (DATA_WIDTH=8, ACC_WIDTH=16): 4 beats, all operands 127 -> every C = -1020 without MMU_SAT_EN, 32767 with it.
- Reset mid-DRAIN: rst_i low 1 cycle during DRAIN -> out_valid=0, busy=0 immediately. Then K=1 with A=3, B=5 everywhere -> all C=15, with no residue from the aborted run.
- Single beat signed: K=1 with in_last, A=-2, B=3 everywhere -> all C=-6; FSM goes IDLE→DRAIN directly.
